dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter in front of the single-ported data memory. Shares one memory port between the pipeline's memory stage (port 0, primary) and a secondary bus master such as a DMA or debug loader (port 1). Each cycle, one granted request drives the memory's address, write-enable, addressing-control and write-data inputs. Read data is registered back to the owning port one cycle later. Port 1 may lock the memory for bounded bursts, and an optional fairness guard stops port 1 from starving.

## Interface
- DATA_WIDTH, 32, address/data width
- MAX_WAIT, 4, cycles port 1 may wait before it is forced ahead of port 0 (fairness build only)
- MAX_BURST, 8, maximum beats in one locked port-1 burst

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- p0_req / p1_req  in  1  access request, held until granted
- p0_we / p1_we  in  1  1 = store, 0 = load
- p0_addr / p1_addr  in  DATA_WIDTH  byte address
- p0_ctrl / p1_ctrl  in  3  addressing control: [1:0] 00 byte, 01 half, 10 word; [2] zero-extend
- p0_wdata / p1_wdata  in  DATA_WIDTH  store data
- p1_lock  in  1  request a locked burst; sampled with p1_req
- p0_gnt / p1_gnt  out  1  combinational grant; the access completes at this clock edge
- p0_rvalid / p1_rvalid  out  1  registered one-cycle acknowledge of the previous cycle's granted access
- p0_rdata / p1_rdata  out  DATA_WIDTH  registered load data
- mem_a  out  DATA_WIDTH  memory address
- mem_we  out  1  memory write enable
- mem_ctrl  out  3  memory addressing control
- mem_wd  out  DATA_WIDTH  memory write data
- mem_rd  in  DATA_WIDTH  memory combinational read data

## Operation
- At most one grant per cycle; p0_gnt && p1_gnt is never true.
- The memory bus mirrors the granted port. With no grant: mem_we=0, mem_a=0, mem_ctrl=3'b010, mem_wd=0.
- FSM states:
  - IDLE: port 0 has priority.
  - BURST1: port 1 owns the memory.
  - YIELD: a one-cycle forced release after a burst.
- IDLE:
  - Grant order is p0, then p1.
  - Exception: if the fairness guard has fired (see Configuration), p1 is granted over p0.
  - If p1 is granted with p1_lock=1, go to BURST1 and set beat_cnt=1.
- BURST1:
  - p1 is granted whenever p1_req=1, even if p0_req=1.
  - beat_cnt increments per granted beat.
  - Exit to IDLE when p1_req=0 or p1_lock=0 (that cycle is arbitrated as IDLE).
  - Exit to YIELD on the granted beat that makes beat_cnt==MAX_BURST.
- YIELD:
  - p1 is not grantable; p0 is granted if requesting.
  - Always returns to IDLE next cycle.
- A port whose req is high but gnt is low must hold all request fields stable. Port 0 uses !p0_gnt as its pipeline stall.
- Response registers, updated at the grant edge:
  - Owning port's rvalid=1 next cycle, for both loads and stores.
  - rdata is loaded with mem_rd only on loads; it holds its value on stores and when idle.
  - rvalid of a port with no grant is 0.

## Timing
- Grant: zero latency (combinational from req and state). Load data: one cycle after grant.
- Store: committed at the grant edge. A port-0 load of the same address in the next cycle returns the new data.
- Reset (asynchronous, any time, including mid-burst):
  - FSM=IDLE, beat_cnt=0, wait_cnt=0.
  - p0/p1_rvalid=0, p0/p1_rdata=0.
  - Both gnt forced to 0 while rst_n=0, so mem_we=0.
  - Requests pending at reset release are arbitrated normally in the first cycle.
- beat_cnt width: clog2(MAX_BURST+1). wait_cnt width: clog2(MAX_WAIT+1). Neither counter wraps; both saturate.
- Simultaneous events:
  - p1_lock dropping on the MAX_BURST-th beat: go to IDLE, not YIELD.
  - Fairness fire in YIELD: ignored until IDLE.

## Configuration
- DMEM_ARB_FAIRNESS_EN defined:
  - wait_cnt increments each cycle with p1_req && !p1_gnt.
  - wait_cnt clears on p1 grant or when p1_req=0.
  - In IDLE, wait_cnt==MAX_WAIT grants p1 over p0 for one access.
- Undefined:
  - wait_cnt is not built.
  - p1 in IDLE is granted only when p0_req=0; bursts still apply.

## Test plan
- Solo port-0 traffic: store word 0xDEADBEEF at 0x100, next cycle load word at 0x100 → p0_gnt=1 on both cycles, p0_rvalid=1 after each, p0_rdata=0xDEADBEEF, p1 outputs stay 0.
- Contention, fairness enabled, MAX_WAIT=4: p0_req held high, p1 load requested at cycle 0 → p1_gnt first asserts at cycle 4, p0_gnt=0 that cycle only. Without the macro, p1_gnt never asserts while p0_req=1.
- Locked burst, MAX_BURST=8: p1_lock=1 with 10 consecutive p1 stores, p0_req=1 throughout → p1 granted 8 beats, YIELD cycle grants p0, then p1 resumes.
- Early burst exit: p1_lock drops after 3 beats → FSM returns to IDLE, next cycle p0 wins with no YIELD.
- Reset mid-burst (beat 5): rst_n pulsed low asynchronously → gnt, rvalid, rdata and mem_we all drop to 0 immediately; after release, p0 wins over the still-locked p1.
- Load extension through the arbiter: memory byte 0x80 at 0x200, p1 lb then lbu → p1_rdata 0xFFFFFF80 then 0x00000080.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: port 0 (pipeline) has priority, port 1 may run locked bursts.
// Build with DMEM_ARB_FAIRNESS_EN to add the port-1 anti-starvation guard.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [DATA_WIDTH-1:0] p0_addr,
    input  logic [2:0]            p0_ctrl,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [DATA_WIDTH-1:0] p1_addr,
    input  logic [2:0]            p1_ctrl,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic                  p1_lock,
    output logic                  p0_gnt,
    output logic                  p1_gnt,
    output logic                  p0_rvalid,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic                  mem_we,
    output logic [2:0]            mem_ctrl,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST1,
        YIELD
    } state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;
    logic          fair_fire;
    logic          idle_p0, idle_p1;
    logic          gnt0, gnt1;
    logic          last_beat;

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!p1_req || p1_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WW'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    assign fair_fire = (wait_cnt == WW'(MAX_WAIT));
`else
    assign fair_fire = 1'b0;
`endif

    // Plain IDLE arbitration, also used for the cycle a burst is abandoned
    assign idle_p1   = p1_req && (fair_fire || !p0_req);
    assign idle_p0   = p0_req && !idle_p1;
    assign last_beat = (beat_cnt >= BW'(MAX_BURST - 1));

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        unique case (state)
            IDLE: begin
                gnt0 = idle_p0;
                gnt1 = idle_p1;
                if (idle_p1 && p1_lock) begin
                    state_nxt = (MAX_BURST == 1) ? YIELD : BURST1;
                    beat_nxt  = BW'(1);
                end
            end
            BURST1: begin
                if (p1_req && p1_lock) begin
                    gnt1 = 1'b1;
                    if (last_beat) begin
                        state_nxt = YIELD;
                        beat_nxt  = BW'(MAX_BURST);
                    end else begin
                        beat_nxt = beat_cnt + BW'(1);
                    end
                end else begin
                    gnt0      = idle_p0;
                    gnt1      = idle_p1;
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                end
            end
            YIELD: begin
                gnt0      = p0_req;
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    // Grants are killed while reset is asserted so no write can slip through
    assign p0_gnt = gnt0 & rst_n;
    assign p1_gnt = gnt1 & rst_n;

    always_comb begin
        mem_a    = '0;
        mem_we   = 1'b0;
        mem_ctrl = 3'b010;
        mem_wd   = '0;
        if (p0_gnt) begin
            mem_a    = p0_addr;
            mem_we   = p0_we;
            mem_ctrl = p0_ctrl;
            mem_wd   = p0_wdata;
        end else if (p1_gnt) begin
            mem_a    = p1_addr;
            mem_we   = p1_we;
            mem_ctrl = p1_ctrl;
            mem_wd   = p1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= p0_gnt;
            p1_rvalid <= p1_gnt;
            if (p0_gnt && !p0_we) begin
                p0_rdata <= mem_rd;
            end
            if (p1_gnt && !p1_we) begin
                p1_rdata <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model.
// Covers priority, fairness, locked bursts, early exit, reset and load extension.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [2:0]  p0_ctrl, p1_ctrl;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;
    logic [2:0]  mem_ctrl;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(
        .DATA_WIDTH(32),
        .MAX_WAIT  (4),
        .MAX_BURST (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .p0_req   (p0_req),
        .p0_we    (p0_we),
        .p0_addr  (p0_addr),
        .p0_ctrl  (p0_ctrl),
        .p0_wdata (p0_wdata),
        .p1_req   (p1_req),
        .p1_we    (p1_we),
        .p1_addr  (p1_addr),
        .p1_ctrl  (p1_ctrl),
        .p1_wdata (p1_wdata),
        .p1_lock  (p1_lock),
        .p0_gnt   (p0_gnt),
        .p1_gnt   (p1_gnt),
        .p0_rvalid(p0_rvalid),
        .p1_rvalid(p1_rvalid),
        .p0_rdata (p0_rdata),
        .p1_rdata (p1_rdata),
        .mem_a    (mem_a),
        .mem_we   (mem_we),
        .mem_ctrl (mem_ctrl),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read with sign/zero extension, write at edge
    logic [7:0] mem [0:1023];
    logic [9:0] ai;
    assign ai = mem_a[9:0];

    always_comb begin
        mem_rd = 32'h0;
        case (mem_ctrl[1:0])
            2'b00: mem_rd = mem_ctrl[2] ? {24'h0, mem[ai]}
                                        : {{24{mem[ai][7]}}, mem[ai]};
            2'b01: mem_rd = mem_ctrl[2] ? {16'h0, mem[ai+10'd1], mem[ai]}
                                        : {{16{mem[ai+10'd1][7]}}, mem[ai+10'd1], mem[ai]};
            default: mem_rd = {mem[ai+10'd3], mem[ai+10'd2], mem[ai+10'd1], mem[ai]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_ctrl[1:0])
                2'b00: mem[ai] <= mem_wd[7:0];
                2'b01: begin
                    mem[ai]       <= mem_wd[7:0];
                    mem[ai+10'd1] <= mem_wd[15:8];
                end
                default: begin
                    mem[ai]       <= mem_wd[7:0];
                    mem[ai+10'd1] <= mem_wd[15:8];
                    mem[ai+10'd2] <= mem_wd[23:16];
                    mem[ai+10'd3] <= mem_wd[31:24];
                end
            endcase
        end
    end

    task automatic clear_inputs();
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_ctrl = 3'b010; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_ctrl = 3'b010; p1_wdata = 0;
        p1_lock = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        p0_req = 1; p0_we = 1; p0_addr = 32'h100; p0_wdata = 32'h1234;
        p1_req = 1; p1_lock = 1;
        #2;
        checks++;
        if ({p1_gnt, p0_gnt} !== 2'b00) begin
            errors++; $display("FAIL rst_gnt: got %b want 00", {p1_gnt, p0_gnt});
        end
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we);
        end
        tick();
        checks++;
        if ({p1_rvalid, p0_rvalid} !== 2'b00) begin
            errors++; $display("FAIL rst_rvalid: got %b want 00", {p1_rvalid, p0_rvalid});
        end
        checks++;
        if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_rdata: got %h/%h want 0/0", p0_rdata, p1_rdata);
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        tick();
        checks++;
        if (mem_a !== 32'h0 || mem_ctrl !== 3'b010 || mem_wd !== 32'h0) begin
            errors++;
            $display("FAIL idle_bus: got a=%h c=%b wd=%h want 0/010/0", mem_a, mem_ctrl, mem_wd);
        end
    endtask

    task automatic test_solo_p0();
        p0_req = 1; p0_we = 1; p0_addr = 32'h100; p0_ctrl = 3'b010;
        p0_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (p0_gnt !== 1 || p1_gnt !== 0 || mem_we !== 1 || mem_a !== 32'h100) begin
            errors++;
            $display("FAIL solo_store_gnt: got g0=%b g1=%b we=%b a=%h want 1/0/1/100",
                     p0_gnt, p1_gnt, mem_we, mem_a);
        end
        tick();
        checks++;
        if (p0_rvalid !== 1 || p0_rdata !== 32'h0) begin
            errors++;
            $display("FAIL solo_store_resp: got v=%b d=%h want 1/0", p0_rvalid, p0_rdata);
        end
        p0_we = 0; p0_wdata = 0;
        #1;
        checks++;
        if (p0_gnt !== 1 || mem_we !== 0) begin
            errors++; $display("FAIL solo_load_gnt: got g=%b we=%b want 1/0", p0_gnt, mem_we);
        end
        tick();
        checks++;
        if (p0_rvalid !== 1 || p0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL solo_load_resp: got v=%b d=%h want 1/deadbeef", p0_rvalid, p0_rdata);
        end
        checks++;
        if (p1_rvalid !== 0 || p1_rdata !== 32'h0) begin
            errors++; $display("FAIL solo_p1_quiet: got v=%b d=%h want 0/0", p1_rvalid, p1_rdata);
        end
        clear_inputs();
        tick();
        checks++;
        if (p0_rvalid !== 0 || p0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL solo_idle_hold: got v=%b d=%h want 0/deadbeef", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_fairness();
        int first = -1;
        int n0 = 0;
        int exp_first;
        int exp_n0;
        logic g1;
`ifdef DMEM_ARB_FAIRNESS_EN
        exp_first = 4;
        exp_n0 = 7;
`else
        exp_first = -1;
        exp_n0 = 8;
`endif
        p0_req = 1; p0_addr = 32'h100;
        p1_req = 1; p1_addr = 32'h104;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (p0_gnt && p1_gnt) begin
                errors++; $display("FAIL fair_excl: both granted at cycle %0d", c);
            end
            g1 = p1_gnt;
            if (g1 && first < 0) first = c;
            if (p0_gnt) n0++;
            tick();
            if (g1) p1_req = 0;
        end
        checks++;
        if (first != exp_first) begin
            errors++; $display("FAIL fair_first: got %0d want %0d", first, exp_first);
        end
        checks++;
        if (n0 != exp_n0) begin
            errors++; $display("FAIL fair_p0_count: got %0d want %0d", n0, exp_n0);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_burst();
        logic [1:0] exp_g [0:10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                     2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
        logic [1:0] g;
        int beat = 0;
        for (int c = 0; c < 11; c++) begin
            p1_req = (beat < 10); p1_lock = 1; p1_we = 1;
            p1_addr = 32'h300 + 32'(4 * beat); p1_wdata = 32'(beat);
            p0_req = (c >= 1 && c <= 8); p0_addr = 32'h100;
            #1;
            g = {p1_gnt, p0_gnt};
            checks++;
            if (g !== exp_g[c]) begin
                errors++; $display("FAIL burst_gnt[%0d]: got %b want %b", c, g, exp_g[c]);
            end
            tick();
            checks++;
            if ({p1_rvalid, p0_rvalid} !== exp_g[c]) begin
                errors++;
                $display("FAIL burst_rvalid[%0d]: got %b want %b", c,
                         {p1_rvalid, p0_rvalid}, exp_g[c]);
            end
            if (g[1]) beat++;
        end
        checks++;
        if (beat != 10) begin
            errors++; $display("FAIL burst_beats: got %0d want 10", beat);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_early_exit();
        logic [1:0] exp_g [0:4] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        logic [1:0] g;
        for (int c = 0; c < 5; c++) begin
            p1_req = 1; p1_lock = (c < 3); p1_addr = 32'h104;
            p0_req = (c >= 1 && c <= 3); p0_addr = 32'h100;
            #1;
            g = {p1_gnt, p0_gnt};
            checks++;
            if (g !== exp_g[c]) begin
                errors++; $display("FAIL early_gnt[%0d]: got %b want %b", c, g, exp_g[c]);
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_extension();
        p0_req = 1; p0_we = 1; p0_addr = 32'h200; p0_ctrl = 3'b010;
        p0_wdata = 32'h00000080;
        tick();
        checks++;
        if (p0_rvalid !== 1 || p0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ext_store_hold: got v=%b d=%h want 1/deadbeef", p0_rvalid, p0_rdata);
        end
        clear_inputs();
        p1_req = 1; p1_addr = 32'h200; p1_ctrl = 3'b000;
        tick();
        checks++;
        if (p1_rvalid !== 1 || p1_rdata !== 32'hFFFFFF80) begin
            errors++; $display("FAIL ext_lb: got v=%b d=%h want 1/ffffff80", p1_rvalid, p1_rdata);
        end
        p1_ctrl = 3'b100;
        tick();
        checks++;
        if (p1_rvalid !== 1 || p1_rdata !== 32'h00000080) begin
            errors++; $display("FAIL ext_lbu: got v=%b d=%h want 1/00000080", p1_rvalid, p1_rdata);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        p1_req = 1; p1_lock = 1; p1_addr = 32'h200; p1_ctrl = 3'b010;
        tick();
        p0_req = 1; p0_we = 1; p0_addr = 32'h400; p0_wdata = 32'h55;
        for (int c = 1; c < 5; c++) tick();
        #1;
        checks++;
        if (p1_gnt !== 1 || p0_gnt !== 0 || p1_rvalid !== 1 || p1_rdata !== 32'h80) begin
            errors++;
            $display("FAIL mid_pre: got g1=%b g0=%b v=%b d=%h want 1/0/1/80",
                     p1_gnt, p0_gnt, p1_rvalid, p1_rdata);
        end
        #1;
        rst_n = 0;
        #1;
        checks++;
        if ({p1_gnt, p0_gnt} !== 2'b00 || mem_we !== 0) begin
            errors++;
            $display("FAIL mid_rst_gnt: got g=%b we=%b want 00/0", {p1_gnt, p0_gnt}, mem_we);
        end
        checks++;
        if ({p1_rvalid, p0_rvalid} !== 2'b00 || p1_rdata !== 0 || p0_rdata !== 0) begin
            errors++;
            $display("FAIL mid_rst_resp: got v=%b d1=%h d0=%h want 00/0/0",
                     {p1_rvalid, p0_rvalid}, p1_rdata, p0_rdata);
        end
        #1;
        rst_n = 1;
        #1;
        checks++;
        if ({p1_gnt, p0_gnt} !== 2'b01 || mem_we !== 1) begin
            errors++;
            $display("FAIL mid_release: got g=%b we=%b want 01/1", {p1_gnt, p0_gnt}, mem_we);
        end
        tick();
        checks++;
        if ({p1_rvalid, p0_rvalid} !== 2'b01) begin
            errors++; $display("FAIL mid_resp: got %b want 01", {p1_rvalid, p0_rvalid});
        end
        p0_req = 0;
        #1;
        checks++;
        if ({p1_gnt, p0_gnt} !== 2'b10) begin
            errors++; $display("FAIL mid_p1_again: got %b want 10", {p1_gnt, p0_gnt});
        end
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_solo_p0();
        test_fairness();
        test_burst();
        test_early_exit();
        test_extension();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
